multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/riscv_ctrl_pkg.sv | 43 ++++
 rtl/multicycle_ctrl_wait_timer.sv | 30 +++
 rtl/multicycle_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V control unit: state
// encodings, major opcodes, ALU operation codes and fault codes.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_EXEC_I = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_FAULT  = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH1 = 2'b11;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_ILLEGAL = 2'b01;
    localparam logic [1:0] FC_TIMEOUT = 2'b10;

    // States in which the FSM waits on mem_ready and may time out.
    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_wait_timer.sv
// Memory wait timer: counts consecutive stalled cycles and flags the
// cycle in which the stall count reaches TIMEOUT_CYC.
module wait_timer #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] r_count;

    // Stall counter; clear wins over counting so a state change restarts it.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (count_en) begin
            r_count <= r_count + CW'(1);
        end
    end

    // This stalled cycle is the TIMEOUT_CYC-th in a row; the FSM leaves the
    // wait state on this edge, so the counter never runs past the limit.
    assign expired = count_en && (r_count == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM with retired-instruction counter,
// memory-stall timeout and sticky fault reporting.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        ir_write,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        pc_source,
    output logic [1:0]  aluop,
    output logic [3:0]  state,
    output logic [31:0] retired,
    output logic        fault,
    output logic [1:0]  fault_code
);

    state_t      r_state;
    state_t      w_next_state;
    logic [6:0]  r_opcode;
    logic [31:0] r_retired;
    logic        r_fault;
    logic [1:0]  r_fault_code;
    logic [1:0]  w_fault_code_next;
    logic        w_expired;
    logic        w_clear;
    logic        w_count_en;

    assign w_count_en = is_wait_state(r_state) && !mem_ready;
    assign w_clear    = (w_next_state != r_state) || mem_ready;

    wait_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_clear),
        .count_en (w_count_en),
        .expired  (w_expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Opcode capture during DECODE: the IR is loaded on the edge entering
    // DECODE, so the opcode input is valid throughout that cycle.
    always_ff @(posedge clk) begin
        if (r_state == S_DECODE) begin
            r_opcode <= opcode;
        end
    end

    // Retired count bumps on every completion edge back into FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_retired <= '0;
        end else if ((w_next_state == S_FETCH) &&
                     ((r_state == S_MEMWB) || (r_state == S_MEMWR) ||
                      (r_state == S_ALUWB) || (r_state == S_BRANCH))) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    // Sticky fault flag and cause, captured on entry to FAULT.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault      <= 1'b0;
            r_fault_code <= FC_NONE;
        end else if ((w_next_state == S_FAULT) && (r_state != S_FAULT)) begin
            r_fault      <= 1'b1;
            r_fault_code <= w_fault_code_next;
        end
    end

    // Next-state logic, including illegal-opcode and timeout fault causes.
    always_comb begin
        w_next_state      = r_state;
        w_fault_code_next = FC_NONE;
        case (r_state)
            S_FETCH: begin
                if (mem_ready) begin
                    w_next_state = S_DECODE;
                end else if (w_expired) begin
                    w_next_state      = S_FAULT;
                    w_fault_code_next = FC_TIMEOUT;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
                    OP_RTYPE:          w_next_state = S_EXEC_R;
                    OP_ITYPE:          w_next_state = S_EXEC_I;
                    OP_BRANCH:         w_next_state = S_BRANCH;
                    default: begin
                        w_next_state      = S_FAULT;
                        w_fault_code_next = FC_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: w_next_state = (r_opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem_ready) begin
                    w_next_state = S_MEMWB;
                end else if (w_expired) begin
                    w_next_state      = S_FAULT;
                    w_fault_code_next = FC_TIMEOUT;
                end
            end
            S_MEMWB: w_next_state = S_FETCH;
            S_MEMWR: begin
                if (mem_ready) begin
                    w_next_state = S_FETCH;
                end else if (w_expired) begin
                    w_next_state      = S_FAULT;
                    w_fault_code_next = FC_TIMEOUT;
                end
            end
            S_EXEC_R: w_next_state = S_ALUWB;
            S_EXEC_I: w_next_state = S_ALUWB;
            S_ALUWB:  w_next_state = S_FETCH;
            S_BRANCH: w_next_state = S_FETCH;
            S_FAULT:  w_next_state = S_FAULT;
            default:  w_next_state = S_FETCH;
        endcase
    end

    // Moore control decode; only FETCH's IR/PC writes wait on mem_ready.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REGB;
        pc_source     = 1'b0;
        aluop         = ALUOP_ADD;
        case (r_state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: alu_src_b = SRCB_IMMSH1;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                aluop     = ALUOP_FUNCT;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_ALUWB: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                aluop         = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 1'b1;
            end
            default: ;
        endcase
    end

    assign state      = r_state;
    assign retired    = r_retired;
    assign fault      = r_fault;
    assign fault_code = r_fault_code;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl.
module tb_multicycle_ctrl;
    import riscv_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, ir_write, mem_req, mem_we, iord;
    logic        reg_write, mem_to_reg, alu_src_a, pc_source, fault;
    logic [1:0]  alu_src_b, aluop, fault_code;
    logic [3:0]  state;
    logic [31:0] retired;
    logic [13:0] w_ctrl;

    int n_total = 0;
    int n_pass  = 0;

    multicycle_ctrl #(.TIMEOUT_CYC(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .ir_write      (ir_write),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .iord          (iord),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .pc_source     (pc_source),
        .aluop         (aluop),
        .state         (state),
        .retired       (retired),
        .fault         (fault),
        .fault_code    (fault_code)
    );

    always #5 clk = ~clk;

    // {pc_write, pc_write_cond, ir_write, mem_req, mem_we, iord,
    //  reg_write, mem_to_reg, alu_src_a, alu_src_b[1:0], pc_source, aluop[1:0]}
    assign w_ctrl = {pc_write, pc_write_cond, ir_write, mem_req, mem_we, iord,
                     reg_write, mem_to_reg, alu_src_a, alu_src_b, pc_source, aluop};

    localparam logic [13:0] C_FETCH_W = 14'b0_0_0_1_0_0_0_0_0_01_0_00;
    localparam logic [13:0] C_FETCH_R = 14'b1_0_1_1_0_0_0_0_0_01_0_00;
    localparam logic [13:0] C_DECODE  = 14'b0_0_0_0_0_0_0_0_0_11_0_00;
    localparam logic [13:0] C_MEMADR  = 14'b0_0_0_0_0_0_0_0_1_10_0_00;
    localparam logic [13:0] C_MEMRD   = 14'b0_0_0_1_0_1_0_0_0_00_0_00;
    localparam logic [13:0] C_MEMWB   = 14'b0_0_0_0_0_0_1_1_0_00_0_00;
    localparam logic [13:0] C_MEMWR   = 14'b0_0_0_1_1_1_0_0_0_00_0_00;
    localparam logic [13:0] C_EXEC_R  = 14'b0_0_0_0_0_0_0_0_1_00_0_10;
    localparam logic [13:0] C_EXEC_I  = 14'b0_0_0_0_0_0_0_0_1_10_0_00;
    localparam logic [13:0] C_ALUWB   = 14'b0_0_0_0_0_0_1_0_0_00_0_00;
    localparam logic [13:0] C_BRANCH  = 14'b0_1_0_0_0_0_0_0_1_00_1_01;
    localparam logic [13:0] C_NONE    = 14'b0;

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LD  = 7'b0000011;
    localparam logic [6:0] OPC_ST  = 7'b0100011;
    localparam logic [6:0] OPC_BR  = 7'b1100011;
    localparam logic [6:0] OPC_ILL = 7'b1111111;

    typedef struct {
        logic        rst;
        logic [6:0]  opc;
        logic        rdy;
        logic [3:0]  st;
        logic [13:0] ctrl;
        logic [31:0] ret;
        logic        flt;
        logic [1:0]  fc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic [6:0] opc, input logic rdy,
                                input state_t st, input logic [13:0] ctrl,
                                input logic [31:0] ret, input logic flt, input logic [1:0] fc);
        vec_t v;
        v.rst = rst; v.opc = opc; v.rdy = rdy; v.st = st;
        v.ctrl = ctrl; v.ret = ret; v.flt = flt; v.fc = fc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Drive one cycle's inputs, compare outputs mid-cycle, then advance.
    task automatic apply(input vec_t v, input string tag);
        reset     = v.rst;
        opcode    = v.opc;
        mem_ready = v.rdy;
        #2;
        chk({tag, " state"},   32'(state),      32'(v.st));
        chk({tag, " ctrl"},    32'(w_ctrl),     32'(v.ctrl));
        chk({tag, " retired"}, retired,         v.ret);
        chk({tag, " fault"},   32'(fault),      32'(v.flt));
        chk({tag, " fcode"},   32'(fault_code), 32'(v.fc));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        mem_ready = 1'b0;
        opcode    = 7'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // R, load with 3 stall cycles, branch, I, store, then illegal opcode.
        tbl.push_back(mk(0, OPC_R,   0, S_FETCH,  C_FETCH_W, 0, 0, 2'b00));
        tbl.push_back(mk(0, OPC_R,   1, S_FETCH,  C_FETCH_R, 0, 0, 2'b00));
        tbl.push_back(mk(0, OPC_R,   1, S_DECODE, C_DECODE,  0, 0, 2'b00));
        tbl.push_back(mk(0, OPC_R,   1, S_EXEC_R, C_EXEC_R,  0, 0, 2'b00));
        tbl.push_back(mk(0, OPC_R,   1, S_ALUWB,  C_ALUWB,   0, 0, 2'b00));
        tbl.push_back(mk(0, OPC_LD,  1, S_FETCH,  C_FETCH_R, 1, 0, 2'b00));
        tbl.push_back(mk(0, OPC_LD,  1, S_DECODE, C_DECODE,  1, 0, 2'b00));
        tbl.push_back(mk(0, OPC_LD,  1, S_MEMADR, C_MEMADR,  1, 0, 2'b00));
        tbl.push_back(mk(0, OPC_LD,  0, S_MEMRD,  C_MEMRD,   1, 0, 2'b00));
        tbl.push_back(mk(0, OPC_LD,  0, S_MEMRD,  C_MEMRD,   1, 0, 2'b00));
        tbl.push_back(mk(0, OPC_LD,  0, S_MEMRD,  C_MEMRD,   1, 0, 2'b00));
        tbl.push_back(mk(0, OPC_LD,  1, S_MEMRD,  C_MEMRD,   1, 0, 2'b00));
        tbl.push_back(mk(0, OPC_LD,  1, S_MEMWB,  C_MEMWB,   1, 0, 2'b00));
        tbl.push_back(mk(0, OPC_BR,  1, S_FETCH,  C_FETCH_R, 2, 0, 2'b00));
        tbl.push_back(mk(0, OPC_BR,  1, S_DECODE, C_DECODE,  2, 0, 2'b00));
        tbl.push_back(mk(0, OPC_BR,  1, S_BRANCH, C_BRANCH,  2, 0, 2'b00));
        tbl.push_back(mk(0, OPC_I,   1, S_FETCH,  C_FETCH_R, 3, 0, 2'b00));
        tbl.push_back(mk(0, OPC_I,   1, S_DECODE, C_DECODE,  3, 0, 2'b00));
        tbl.push_back(mk(0, OPC_I,   1, S_EXEC_I, C_EXEC_I,  3, 0, 2'b00));
        tbl.push_back(mk(0, OPC_I,   1, S_ALUWB,  C_ALUWB,   3, 0, 2'b00));
        tbl.push_back(mk(0, OPC_ST,  1, S_FETCH,  C_FETCH_R, 4, 0, 2'b00));
        tbl.push_back(mk(0, OPC_ST,  1, S_DECODE, C_DECODE,  4, 0, 2'b00));
        tbl.push_back(mk(0, OPC_ST,  1, S_MEMADR, C_MEMADR,  4, 0, 2'b00));
        tbl.push_back(mk(0, OPC_ST,  1, S_MEMWR,  C_MEMWR,   4, 0, 2'b00));
        tbl.push_back(mk(0, OPC_ILL, 0, S_FETCH,  C_FETCH_W, 5, 0, 2'b00));
        tbl.push_back(mk(0, OPC_ILL, 1, S_FETCH,  C_FETCH_R, 5, 0, 2'b00));
        tbl.push_back(mk(0, OPC_ILL, 1, S_DECODE, C_DECODE,  5, 0, 2'b00));
        tbl.push_back(mk(0, OPC_ILL, 1, S_FAULT,  C_NONE,    5, 1, 2'b01));

        foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

        // FAULT holds for 20 cycles whatever mem_ready and opcode do.
        for (int i = 0; i < 20; i++) begin
            apply(mk(0, (i % 3 == 0) ? OPC_R : OPC_ILL, 1'(i & 1), S_FAULT, C_NONE, 5, 1, 2'b01),
                  $sformatf("hold%0d", i));
        end
        apply(mk(1, OPC_R, 1, S_FAULT, C_NONE,    5, 1, 2'b01), "fault_rst");
        apply(mk(0, OPC_R, 0, S_FETCH, C_FETCH_W, 0, 0, 2'b00), "after_fault_rst");

        // 16 stalled FETCH cycles -> timeout fault.
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            apply(mk(0, OPC_R, 0, S_FETCH, C_FETCH_W, 0, 0, 2'b00), $sformatf("to_wait%0d", i));
        end
        apply(mk(0, OPC_R, 1, S_FAULT, C_NONE, 0, 1, 2'b10), "to_fault");
        apply(mk(0, OPC_R, 1, S_FAULT, C_NONE, 0, 1, 2'b10), "to_fault_hold");

        // 14 stalls then ready in cycle 15 -> DECODE, no fault.
        do_reset();
        for (int i = 1; i <= 14; i++) begin
            apply(mk(0, OPC_R, 0, S_FETCH, C_FETCH_W, 0, 0, 2'b00), $sformatf("nm_wait%0d", i));
        end
        apply(mk(0, OPC_R,  1, S_FETCH,  C_FETCH_R, 0, 0, 2'b00), "nm_ready15");
        apply(mk(0, OPC_R,  1, S_DECODE, C_DECODE,  0, 0, 2'b00), "nm_decode");
        apply(mk(0, OPC_R,  1, S_EXEC_R, C_EXEC_R,  0, 0, 2'b00), "nm_exec");
        apply(mk(0, OPC_R,  1, S_ALUWB,  C_ALUWB,   0, 0, 2'b00), "nm_aluwb");

        // Store stalled in MEMWR, then reset together with mem_ready.
        apply(mk(0, OPC_ST, 1, S_FETCH,  C_FETCH_R, 1, 0, 2'b00), "rw_fetch");
        apply(mk(0, OPC_ST, 1, S_DECODE, C_DECODE,  1, 0, 2'b00), "rw_decode");
        apply(mk(0, OPC_ST, 1, S_MEMADR, C_MEMADR,  1, 0, 2'b00), "rw_memadr");
        apply(mk(0, OPC_ST, 0, S_MEMWR,  C_MEMWR,   1, 0, 2'b00), "rw_stall");
        apply(mk(1, OPC_ST, 1, S_MEMWR,  C_MEMWR,   1, 0, 2'b00), "rw_reset");
        apply(mk(0, OPC_ST, 0, S_FETCH,  C_FETCH_W, 0, 0, 2'b00), "rw_after");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
